// File: rtl/tug_playfield.sv
// Tug-of-war playfield: moves a one-hot light along an LED row from per-player press pulses,
// detects wins and keeps saturating round scores. Optional macro TUG_AUTO_RESTART_EN adds a timed
// return to play after a win.
module tug_playfield #(
  parameter int unsigned NUM_LEDS       = 9,
  parameter int unsigned SCORE_W        = 3,
  parameter int unsigned RESTART_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                left_press,
  input  logic                right_press,
  input  logic                restart,
  output logic [NUM_LEDS-1:0] leds,
  output logic                win_left,
  output logic                win_right,
  output logic                game_over,
  output logic [SCORE_W-1:0]  score_left,
  output logic [SCORE_W-1:0]  score_right
);

  localparam int unsigned POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] Centre = POS_W'(NUM_LEDS / 2);
  localparam logic [POS_W-1:0] LastPos = POS_W'(NUM_LEDS - 1);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  typedef enum logic [1:0] {StPlay, StWinL, StWinR} state_e;

  state_e               state_q, state_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [SCORE_W-1:0]   score_l_q, score_l_d;
  logic [SCORE_W-1:0]   score_r_q, score_r_d;
  logic [NUM_LEDS-1:0]  leds_d;
  logic                 auto_exit;

`ifdef TUG_AUTO_RESTART_EN
  localparam int unsigned CNT_W = $clog2(RESTART_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign auto_exit = (cnt_q == '0);

  // Loaded on win entry; the win state exits on the edge after it reaches zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StPlay && state_d != StPlay) begin
      cnt_d = CNT_W'(RESTART_CYCLES);
    end else if (state_q != StPlay && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign auto_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    unique case (state_q)
      StPlay: begin
        if (restart) begin
          pos_d = Centre;
        end else if (left_press && right_press) begin
          pos_d = pos_q;
        end else if (left_press) begin
          if (pos_q == LastPos) begin
            state_d = StWinL;
            if (score_l_q != ScoreMax) score_l_d = score_l_q + 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (right_press) begin
          if (pos_q == '0) begin
            state_d = StWinR;
            if (score_r_q != ScoreMax) score_r_d = score_r_q + 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      StWinL, StWinR: begin
        if (restart || auto_exit) begin
          state_d = StPlay;
          pos_d   = Centre;
        end
      end
      default: begin
        state_d = StPlay;
        pos_d   = Centre;
      end
    endcase
  end

  // Outputs are decoded from next state so they are registered alongside it.
  always_comb begin
    leds_d = '0;
    if (state_d == StPlay) leds_d = NUM_LEDS'(1) << pos_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StPlay;
      pos_q     <= Centre;
      score_l_q <= '0;
      score_r_q <= '0;
      leds      <= NUM_LEDS'(1) << Centre;
      win_left  <= 1'b0;
      win_right <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      leds      <= leds_d;
      win_left  <= (state_d == StWinL);
      win_right <= (state_d == StWinR);
      game_over <= (state_d != StPlay);
    end
  end

  assign score_left  = score_l_q;
  assign score_right = score_r_q;

endmodule

// File: tb/tb_tug_playfield.sv
// Scoreboard bench for tug_playfield: directed steps push expected outputs, a monitor pops and
// compares them after each clock edge or an asynchronous-reset probe.
module tb_tug_playfield;

  localparam logic [8:0] Ctr = 9'b000010000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_press = 1'b0;
  logic       right_press = 1'b0;
  logic       restart = 1'b0;
  logic [8:0] leds;
  logic       win_left, win_right, game_over;
  logic [2:0] score_left, score_right;

  tug_playfield #(
    .NUM_LEDS      (9),
    .SCORE_W       (3),
    .RESTART_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .left_press (left_press),
    .right_press(right_press),
    .restart    (restart),
    .leds       (leds),
    .win_left   (win_left),
    .win_right  (win_right),
    .game_over  (game_over),
    .score_left (score_left),
    .score_right(score_right)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] leds;
    logic       wl;
    logic       wr;
    logic [2:0] sl;
    logic [2:0] sr;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  event async_chk;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_chk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (leds !== e.leds || win_left !== e.wl || win_right !== e.wr ||
            game_over !== (e.wl | e.wr) || score_left !== e.sl || score_right !== e.sr) begin
          n_fail++;
          $display("FAIL %s: got leds=%b wl=%b wr=%b go=%b sl=%0d sr=%0d, want leds=%b wl=%b wr=%b go=%b sl=%0d sr=%0d",
                   e.name, leds, win_left, win_right, game_over, score_left, score_right,
                   e.leds, e.wl, e.wr, e.wl | e.wr, e.sl, e.sr);
        end
      end
    end
  end

  task automatic push(input logic [8:0] el, input logic ewl, input logic ewr,
                      input logic [2:0] esl, input logic [2:0] esr, input string nm);
    exp_t e;
    e.leds = el; e.wl = ewl; e.wr = ewr; e.sl = esl; e.sr = esr; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic l, input logic r, input logic rs, input logic chk,
                      input logic [8:0] el, input logic ewl, input logic ewr,
                      input logic [2:0] esl, input logic [2:0] esr, input string nm);
    @(negedge clk);
    left_press = l; right_press = r; restart = rs;
    if (chk) push(el, ewl, ewr, esl, esr, nm);
    @(posedge clk);
    #1;
    left_press = 1'b0; right_press = 1'b0; restart = 1'b0;
  endtask

  task automatic async_reset(input string nm);
    @(negedge clk);
    reset = 1'b1;
    push(Ctr, 1'b0, 1'b0, 3'd0, 3'd0, nm);
    ->async_chk;
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] sr_exp;
    logic [8:0] lv;
    step(0, 0, 0, 1, Ctr, 0, 0, 0, 0, "reset_hold1");
    step(0, 0, 0, 1, Ctr, 0, 0, 0, 0, "reset_hold2");
    release_reset();
    step(0, 0, 0, 1, Ctr, 0, 0, 0, 0, "idle_after_reset");
    step(1, 0, 0, 1, 9'b000100000, 0, 0, 0, 0, "left_pos5");
    step(1, 0, 0, 1, 9'b001000000, 0, 0, 0, 0, "left_pos6");
    step(1, 0, 0, 1, 9'b010000000, 0, 0, 0, 0, "left_pos7");
    async_reset("async_reset_pos7");
    step(0, 0, 0, 1, Ctr, 0, 0, 0, 0, "reset_held_pos7");
    release_reset();
    step(1, 0, 0, 1, 9'b000100000, 0, 0, 0, 0, "left1");
    step(1, 0, 0, 1, 9'b001000000, 0, 0, 0, 0, "left2");
    step(1, 0, 0, 1, 9'b010000000, 0, 0, 0, 0, "left3");
    step(1, 0, 0, 1, 9'b100000000, 0, 0, 0, 0, "left4_edge");
    step(1, 0, 0, 1, 9'b000000000, 1, 0, 1, 0, "left5_win");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 9'b0, 1, 0, 1, 0, "winl_ignores_right");
    step(0, 0, 1, 1, Ctr, 0, 0, 1, 0, "restart_from_winl");
    step(1, 1, 0, 1, Ctr, 0, 0, 1, 0, "tie_cancels");
    step(0, 1, 0, 1, 9'b000001000, 0, 0, 1, 0, "right_after_tie");
    step(1, 0, 1, 1, Ctr, 0, 0, 1, 0, "restart_beats_left");

    for (int k = 1; k <= 8; k++) begin
      sr_exp = (k - 1 > 7) ? 3'd7 : 3'(k - 1);
      lv = 9'b000001000;
      for (int i = 0; i < 4; i++) begin
        step(0, 1, 0, (i == 3), lv, 0, 0, 1, sr_exp, "right_walk_edge");
        lv = lv >> 1;
      end
      sr_exp = (k > 7) ? 3'd7 : 3'(k);
      step(0, 1, 0, 1, 9'b0, 0, 1, 1, sr_exp, $sformatf("right_win%0d", k));
      if (k == 1) step(1, 0, 0, 1, 9'b0, 0, 1, 1, sr_exp, "winr_ignores_left");
      step(0, 0, 1, 1, Ctr, 0, 0, 1, sr_exp, "restart_from_winr");
    end

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, Ctr, 0, 0, 0, 0, "");
    step(1, 0, 0, 1, 9'b0, 1, 0, 2, 7, "left_win_timed");
`ifdef TUG_AUTO_RESTART_EN
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 9'b0, 1, 0, 2, 7, "auto_win_hold");
    step(0, 0, 0, 1, Ctr, 0, 0, 2, 7, "auto_restart");
`else
    for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 9'b0, 1, 0, 2, 7, "win_held");
`endif
    async_reset("async_reset_final");
    step(0, 0, 0, 1, Ctr, 0, 0, 0, 0, "reset_held_final");
    release_reset();
    step(0, 0, 0, 1, Ctr, 0, 0, 0, 0, "idle_final");

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
